// File: rtl/next_queue_animator_if.sv
// Pixel/queue bus of the next-piece preview animator: raster position,
// frame and queue events, piece queue in, registered pixel out.
interface next_queue_animator_if #(
  parameter int PIECE_COUNT = 3
);
  logic [9:0]                  VGA_row;
  logic [9:0]                  VGA_col;
  logic                        frame_start;
  logic                        queue_shift;
  logic                        hide;
  logic [PIECE_COUNT-1:0][2:0] pieces_queue;
  logic [23:0]                 output_color;
  logic                        active;

  modport master (
    output VGA_row, VGA_col, frame_start, queue_shift, hide, pieces_queue,
    input  output_color, active
  );

  modport slave (
    input  VGA_row, VGA_col, frame_start, queue_shift, hide, pieces_queue,
    output output_color, active
  );
endinterface

// File: rtl/next_queue_animator.sv
// Next-piece preview with slide animation. A snapshot of the queue is drawn
// shifted down by a pixel offset that shrinks by SLIDE_STEP each frame after
// the queue advances, so the pieces glide up one slot instead of snapping.
module next_queue_animator #(
  parameter int VSTART      = 40,
  parameter int HSTART      = 480,
  parameter int PIECE_COUNT = 3,
  parameter int TILE_H      = 16,
  parameter int TILE_W      = 16,
  parameter int SLOT_ROWS   = 3,
  parameter int GRID_COLS   = 6,
  parameter int SLIDE_STEP  = 4
) (
  input  logic                  clk,
  input  logic                  rst_l,
  next_queue_animator_if.slave  bus
);

  localparam int SLOT_PX   = SLOT_ROWS * TILE_H;
  localparam int GRID_ROWS = SLOT_ROWS * PIECE_COUNT + 2;
  localparam int WIN_H     = GRID_ROWS * TILE_H;
  localparam int WIN_W     = GRID_COLS * TILE_W;
  localparam int OFF_W     = $clog2(SLOT_PX + 1);

  // Tile type codes
  localparam logic [2:0] TILE_BLANK = 3'd0;
  localparam logic [2:0] TILE_I     = 3'd1;
  localparam logic [2:0] TILE_O     = 3'd2;
  localparam logic [2:0] TILE_T     = 3'd3;
  localparam logic [2:0] TILE_S     = 3'd4;
  localparam logic [2:0] TILE_Z     = 3'd5;
  localparam logic [2:0] TILE_J     = 3'd6;
  localparam logic [2:0] TILE_L     = 3'd7;

  localparam logic [23:0] TILE_BLANK_COLOR  = 24'h1C1C1C;
  localparam logic [23:0] TETROMINO_I_COLOR = 24'h00FFFF;
  localparam logic [23:0] TETROMINO_O_COLOR = 24'hFFFF00;
  localparam logic [23:0] TETROMINO_T_COLOR = 24'h800080;
  localparam logic [23:0] TETROMINO_S_COLOR = 24'h00FF00;
  localparam logic [23:0] TETROMINO_Z_COLOR = 24'hFF0000;
  localparam logic [23:0] TETROMINO_J_COLOR = 24'h0000FF;
  localparam logic [23:0] TETROMINO_L_COLOR = 24'hFFA500;

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_SLIDING = 1'b1;

  // ORIENTATION_0 footprint in a 2x4 box; bit index = row*4 + col.
  function automatic logic [7:0] shape_mask(input logic [2:0] t);
    case (t)
      TILE_I:  shape_mask = 8'b0000_1111;
      TILE_O:  shape_mask = 8'b0011_0011;
      TILE_T:  shape_mask = 8'b0010_0111;
      TILE_S:  shape_mask = 8'b0011_0110;
      TILE_Z:  shape_mask = 8'b0110_0011;
      TILE_J:  shape_mask = 8'b0111_0001;
      TILE_L:  shape_mask = 8'b0111_0100;
      default: shape_mask = 8'b0000_0000;
    endcase
  endfunction

  function automatic logic [23:0] piece_color(input logic [2:0] t);
    case (t)
      TILE_I:  piece_color = TETROMINO_I_COLOR;
      TILE_O:  piece_color = TETROMINO_O_COLOR;
      TILE_T:  piece_color = TETROMINO_T_COLOR;
      TILE_S:  piece_color = TETROMINO_S_COLOR;
      TILE_Z:  piece_color = TETROMINO_Z_COLOR;
      TILE_J:  piece_color = TETROMINO_J_COLOR;
      TILE_L:  piece_color = TETROMINO_L_COLOR;
      default: piece_color = TILE_BLANK_COLOR;
    endcase
  endfunction

  logic [0:0]                  state_reg, state_next;
  logic [OFF_W-1:0]            offset_reg, offset_next;
  logic [PIECE_COUNT-1:0][2:0] snap_reg, snap_next;
  logic                        active_reg;
  logic [23:0]                 color_reg;

  // Slide control: a queue shift always restarts the slide, otherwise the
  // offset walks down one step per frame while the snapshot stays frozen.
  always_comb begin
    state_next  = state_reg;
    offset_next = offset_reg;
    snap_next   = snap_reg;
    if (bus.queue_shift) begin
      snap_next   = bus.pieces_queue;
      offset_next = OFF_W'(SLOT_PX);
      state_next  = ST_SLIDING;
    end else if (state_reg == ST_IDLE) begin
      snap_next = bus.pieces_queue;
    end else if (bus.frame_start) begin
      if (offset_reg <= OFF_W'(SLIDE_STEP)) begin
        offset_next = '0;
        state_next  = ST_IDLE;
      end else begin
        offset_next = offset_reg - OFF_W'(SLIDE_STEP);
      end
    end
  end

  // Slide state registers
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_reg  <= ST_IDLE;
      offset_reg <= '0;
      snap_reg   <= '0;
    end else begin
      state_reg  <= state_next;
      offset_reg <= offset_next;
      snap_reg   <= snap_next;
    end
  end

  int   y_rel;
  int   tile_row;
  int   tile_col;
  logic in_win;

  // Pixel geometry: window test on the raw raster, tile lookup on the
  // slide-shifted row.
  always_comb begin
    in_win   = (int'(bus.VGA_row) >= VSTART) && (int'(bus.VGA_row) < VSTART + WIN_H) &&
               (int'(bus.VGA_col) >= HSTART) && (int'(bus.VGA_col) < HSTART + WIN_W);
    y_rel    = int'(bus.VGA_row) - VSTART - int'(offset_reg);
    tile_row = y_rel / TILE_H;
    tile_col = (int'(bus.VGA_col) - HSTART) / TILE_W;
  end

  logic [PIECE_COUNT-1:0] slot_hit;

  for (genvar gi = 0; gi < PIECE_COUNT; gi++) begin : g_slot
    logic [7:0] mask;
    logic [2:0] bit_idx;
    int         rel_r;
    int         rel_c;
    logic       hit;

    // Does this slot's piece cover the current tile (I pieces sit one row lower)
    always_comb begin
      mask    = shape_mask(snap_reg[gi]);
      rel_r   = tile_row - (SLOT_ROWS * gi + 2) - ((snap_reg[gi] == TILE_I) ? 1 : 0);
      rel_c   = tile_col - 2;
      bit_idx = {rel_r[0], rel_c[1:0]};
      hit     = 1'b0;
      if (rel_r >= 0 && rel_r < 2 && rel_c >= 0 && rel_c < 4)
        hit = mask[bit_idx];
    end

    assign slot_hit[gi] = hit;
  end

  logic [23:0] pix_color;

  // Lowest-index slot wins should two pieces ever claim the same tile
  always_comb begin
    pix_color = TILE_BLANK_COLOR;
    for (int i = PIECE_COUNT - 1; i >= 0; i--)
      if (slot_hit[i]) pix_color = piece_color(snap_reg[i]);
  end

  // Registered output stage feeding the top-level pixel mux
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      active_reg <= 1'b0;
      color_reg  <= 24'h000000;
    end else begin
      active_reg <= in_win;
      color_reg  <= (in_win && !bus.hide && y_rel >= 0) ? pix_color : TILE_BLANK_COLOR;
    end
  end

  assign bus.active       = active_reg;
  assign bus.output_color = color_reg;

endmodule

// File: tb/tb_next_queue_animator.sv
// Self-checking bench for next_queue_animator: directed scenarios followed by
// random raster/queue traffic, all compared against a tile-level model.
module tb_next_queue_animator;

  localparam int PC        = 3;
  localparam int VSTART    = 40;
  localparam int HSTART    = 480;
  localparam int TILE      = 16;
  localparam int SLOT_PX   = 48;
  localparam int STEP      = 4;
  localparam int WIN_H     = (3 * PC + 2) * TILE;
  localparam int WIN_W     = 6 * TILE;

  localparam logic [23:0] BLANK_C = 24'h1C1C1C;
  localparam logic [23:0] I_C     = 24'h00FFFF;
  localparam logic [23:0] T_C     = 24'h800080;
  localparam logic [23:0] Z_C     = 24'hFF0000;
  localparam logic [23:0] COLORS [8] = '{BLANK_C, I_C, 24'hFFFF00, T_C,
                                         24'h00FF00, Z_C, 24'h0000FF, 24'hFFA500};
  // Cell offsets (row, col) of each piece type at ORIENTATION_0
  localparam int SHAPE_R [8][4] = '{'{0,0,0,0}, '{0,0,0,0}, '{0,0,1,1}, '{0,0,0,1},
                                    '{0,0,1,1}, '{0,0,1,1}, '{0,1,1,1}, '{0,1,1,1}};
  localparam int SHAPE_C [8][4] = '{'{0,0,0,0}, '{0,1,2,3}, '{0,1,0,1}, '{0,1,2,1},
                                    '{1,2,0,1}, '{0,1,1,2}, '{0,0,1,2}, '{2,0,1,2}};

  logic clk = 1'b0;
  logic rst_l;
  int   checks = 0;
  int   failures = 0;

  logic [2:0] m_snap [PC];
  int         m_offset;

  next_queue_animator_if #(.PIECE_COUNT(PC)) bus ();

  next_queue_animator #(.PIECE_COUNT(PC)) dut (
    .clk   (clk),
    .rst_l (rst_l),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("FAIL %s t=%0t observed=%h expected=%h", tag, $time, observed, expected);
    end
  endtask

  task automatic model_reset();
    m_offset = 0;
    for (int i = 0; i < PC; i++) m_snap[i] = 3'd0;
  endtask

  // Expected pixel from the model state and current raster inputs
  task automatic model_render(output logic a, output logic [23:0] c);
    int  row, col, y, tr, tc, t, base;
    bit  done;
    row  = int'(bus.VGA_row);
    col  = int'(bus.VGA_col);
    a    = (row >= VSTART) && (row < VSTART + WIN_H) && (col >= HSTART) && (col < HSTART + WIN_W);
    c    = BLANK_C;
    done = 1'b0;
    if (a && !bus.hide) begin
      y = row - VSTART - m_offset;
      if (y >= 0) begin
        tr = y / TILE;
        tc = (col - HSTART) / TILE;
        for (int i = 0; i < PC; i++) begin
          t    = int'(m_snap[i]);
          base = 2 + 3 * i + ((t == 1) ? 1 : 0);
          if (t != 0 && !done)
            for (int k = 0; k < 4; k++)
              if (!done && tr == base + SHAPE_R[t][k] && tc == 2 + SHAPE_C[t][k]) begin
                c    = COLORS[t];
                done = 1'b1;
              end
        end
      end
    end
  endtask

  task automatic model_advance();
    if (!rst_l) model_reset();
    else if (bus.queue_shift) begin
      for (int i = 0; i < PC; i++) m_snap[i] = bus.pieces_queue[i];
      m_offset = SLOT_PX;
    end else if (m_offset == 0) begin
      for (int i = 0; i < PC; i++) m_snap[i] = bus.pieces_queue[i];
    end else if (bus.frame_start) begin
      m_offset = m_offset - STEP;
    end
  endtask

  // One clock: predict, advance, then compare just after the edge
  task automatic step();
    logic        ea;
    logic [23:0] ec;
    if (!rst_l) begin
      ea = 1'b0;
      ec = 24'h000000;
    end else begin
      model_render(ea, ec);
    end
    model_advance();
    @(posedge clk);
    #1;
    check_value("active", {31'd0, bus.active}, {31'd0, ea});
    check_value("color", {8'd0, bus.output_color}, {8'd0, ec});
    check_value("offset", 32'(dut.offset_reg), 32'(m_offset));
    bus.queue_shift = 1'b0;
    bus.frame_start = 1'b0;
  endtask

  task automatic set_pixel(input int row, input int col);
    bus.VGA_row = 10'(row);
    bus.VGA_col = 10'(col);
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      bus.frame_start = 1'b1;
      step();
      step();
    end
  endtask

  initial begin
    rst_l            = 1'b0;
    bus.frame_start  = 1'b0;
    bus.queue_shift  = 1'b0;
    bus.hide         = 1'b0;
    bus.pieces_queue = {3'd7, 3'd2, 3'd3};   // [0]=T, [1]=O, [2]=L
    set_pixel(72, 512);
    model_reset();

    // Reset held with raster inside the window
    for (int i = 0; i < 3; i++) step();
    check_value("rst_active", {31'd0, bus.active}, 32'd0);
    check_value("rst_color", {8'd0, bus.output_color}, 32'd0);
    $display("reset: active=%0d color=%h offset=%0d", bus.active, bus.output_color, dut.offset_reg);
    rst_l = 1'b1;

    // Static render of queue[0]=T at tile (2,2)
    step();
    step();
    check_value("static_t", {8'd0, bus.output_color}, {8'd0, T_C});
    check_value("static_act", {31'd0, bus.active}, 32'd1);
    set_pixel(72, 700);
    step();
    check_value("outside_act", {31'd0, bus.active}, 32'd0);
    check_value("outside_col", {8'd0, bus.output_color}, {8'd0, BLANK_C});
    $display("static: T at (72,512), outside at col 700 done");

    // Slide after a queue shift
    set_pixel(72, 512);
    bus.queue_shift = 1'b1;
    step();
    check_value("shift_off", 32'(dut.offset_reg), 32'(SLOT_PX));
    step();
    check_value("slide_blank", {8'd0, bus.output_color}, {8'd0, BLANK_C});
    set_pixel(120, 512);
    step();
    check_value("slide_low_t", {8'd0, bus.output_color}, {8'd0, T_C});
    frames(SLOT_PX / STEP);
    check_value("slide_end", 32'(dut.offset_reg), 32'd0);
    set_pixel(72, 512);
    step();
    step();
    check_value("slide_home", {8'd0, bus.output_color}, {8'd0, T_C});
    $display("slide: %0d frames back to offset %0d", SLOT_PX / STEP, dut.offset_reg);

    // Shift coincident with frame, then restart mid-slide
    bus.queue_shift = 1'b1;
    bus.frame_start = 1'b1;
    step();
    check_value("coincide", 32'(dut.offset_reg), 32'(SLOT_PX));
    frames(7);
    check_value("mid_20", 32'(dut.offset_reg), 32'd20);
    bus.pieces_queue[0] = 3'd1;             // I
    bus.queue_shift = 1'b1;
    step();
    check_value("restart", 32'(dut.offset_reg), 32'(SLOT_PX));
    $display("collisions: coincident shift and mid-slide restart done");

    // Frozen snapshot while sliding: the I stays drawn at its shifted row
    bus.pieces_queue = {3'd5, 3'd5, 3'd5};
    set_pixel(VSTART + SLOT_PX + 3 * TILE, 512);
    step();
    step();
    check_value("freeze_i", {8'd0, bus.output_color}, {8'd0, I_C});
    frames(SLOT_PX / STEP);
    set_pixel(72, 512);
    step();
    step();
    check_value("idle_z", {8'd0, bus.output_color}, {8'd0, Z_C});
    bus.pieces_queue[0] = 3'd3;
    step();
    check_value("idle_lag1", {8'd0, bus.output_color}, {8'd0, Z_C});
    step();
    check_value("idle_lag2", {8'd0, bus.output_color}, {8'd0, T_C});
    $display("freeze: snapshot held during slide, IDLE update after two cycles");

    // Hide blanks in-window tiles
    bus.hide = 1'b1;
    step();
    check_value("hide_act", {31'd0, bus.active}, 32'd1);
    check_value("hide_col", {8'd0, bus.output_color}, {8'd0, BLANK_C});
    bus.hide = 1'b0;
    $display("hide: in-window tile blanked");

    // Reset in the middle of a slide
    bus.queue_shift = 1'b1;
    step();
    frames(2);
    rst_l = 1'b0;
    #1;
    check_value("mid_rst_off", 32'(dut.offset_reg), 32'd0);
    check_value("mid_rst_act", {31'd0, bus.active}, 32'd0);
    check_value("mid_rst_col", {8'd0, bus.output_color}, 32'd0);
    model_reset();
    step();
    step();
    rst_l = 1'b1;
    $display("reset mid-slide: offset=%0d", dut.offset_reg);

    // Random traffic
    for (int n = 0; n < 4000; n++) begin
      set_pixel($urandom_range(20, 240), $urandom_range(470, 590));
      bus.frame_start = ($urandom_range(0, 3) == 0);
      bus.queue_shift = ($urandom_range(0, 49) == 0);
      bus.hide        = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 9) == 0) begin
        int j;
        j = int'($urandom_range(0, PC - 1));
        bus.pieces_queue[j] = 3'($urandom_range(0, 7));
      end
      if (bus.queue_shift)
        $display("random shift at cycle %0d queue=%h", n, bus.pieces_queue);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
